permute_iter: RTL and testbench
===============================

# permute_iter

Parametrised, sequential successor to the fixed 16×64-bit word permutation. It holds one NWORDS×WORD_W block in a register and applies a programmable word permutation (forward or inverse) a selectable number of rounds, one round per clock. The block sits between hash-round stages behind a valid/ready handshake on each side.

## Interface
- WORD_W, 64, width of one word in bits
- NWORDS, 16, words per block; total width DW = NWORDS*WORD_W
- IDX_W, 4, index width, equal to clog2(NWORDS)
- PERM, {15,6,13,2,9,4,11,0,5,8,3,12,1,10,7,14}, packed NWORDS×IDX_W table, listed from entry NWORDS-1 down to entry 0. Entry j, bits [j*IDX_W +: IDX_W], is the source word index for output word j. The table must be a bijection.
- RND_W, 4, width of the rounds input
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input block valid
- in_ready  out  1  block can accept input
- in_data  in  DW  input block; word k = bits [k*WORD_W +: WORD_W]
- mode  in  1  0 = forward P, 1 = inverse P⁻¹; sampled at accept
- rounds  in  RND_W  number of permutation applications (0..2^RND_W-1); sampled at accept
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DW  result block
- busy  out  1  high in RUN or DONE

## Operation
- Forward round: word j of the next value = word PERM[j] of the current value.
- Inverse round: word PERM[j] of the next value = word j of the current value.
- Registers:
  - data_q (DW)
  - cnt_q (RND_W)
  - mode_q (1)
  - state (IDLE, RUN, DONE)
- IDLE:
  - in_ready=1.
  - On in_valid: data_q←in_data, mode_q←mode, cnt_q←rounds.
  - If rounds==0, go to DONE (pass-through, data unmodified). Otherwise go to RUN.
- RUN:
  - Each cycle: data_q←round(data_q, mode_q), cnt_q←cnt_q-1.
  - When cnt_q==1 on that edge, go to DONE.
  - in_ready=0. out_valid=0.
- DONE:
  - out_valid=1, out_data=data_q.
  - On out_ready, go to IDLE.
  - While out_ready=0, out_data holds stable and no state changes.
- in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state!=IDLE). All are decoded from registered state only, with no combinational path from inputs.
- A new input is never accepted in the same cycle a result is consumed. The DONE→IDLE transition costs one cycle.
- mode and rounds are ignored except on the accept edge. Changes while busy have no effect.
- in_data is ignored when in_ready=0, even if in_valid=1.
- Reset:
  - Asserting rst at any time, including mid-RUN or in DONE, immediately forces state=IDLE, data_q=0, cnt_q=0, mode_q=0. Any in-flight block is discarded.
  - Output values during and after reset: out_valid=0, busy=0, out_data=0, in_ready=1.
  - No capture happens on an edge while rst is high.
- Simulation-only check: flag an error at elaboration if PERM is not a bijection.

## Timing
- Accept edge at cycle t, with rounds=R:
  - R≥1: out_valid rises at t+R+1, i.e. R permutation cycles plus the DONE register.
  - R=0: out_valid rises at t+1.
- Result consumed on edge u: in_ready=1 from u+1. The earliest next accept is edge u+1.
- Minimum issue interval: R+2 cycles (R≥1) or 2 cycles (R=0).
- The datapath for a round is pure wiring, with one DW-wide mux selecting forward or inverse per word. No arithmetic is performed.
- The cnt_q decrement is done in RND_W bits. cnt_q never wraps, because RUN is only entered with cnt_q≥1.

## Test plan
- **Forward, R=1:** word k=k (64-bit value k). Expect out words, from 15 down to 0: 15,6,13,2,9,4,11,0,5,8,3,12,1,10,7,14, with out_valid at t+2.
- **Inverse, R=1:** apply to the previous output. Expect word k=k restored, at t+2.
- **Permutation order:**
  - Forward, R=4, random data: out_data==in_data at t+5.
  - R=2: word 11 and word 9 unchanged, words 14/8 swapped.
- **R=0 pass-through:** random data is returned unchanged. out_valid at t+1; busy high for exactly 1 cycle when out_ready=1.
- **Backpressure:**
  - R=3, hold out_ready=0 for 6 cycles. out_data stays stable and in_ready=0 throughout.
  - Present a second block with in_valid=1 and different mode/rounds during this time. It is not accepted.
  - After out_ready=1 the second block is accepted one cycle later and its own mode/rounds apply.
- **Reset mid-RUN:**
  - R=15, assert rst 3 cycles after accept. out_valid=0, out_data=0 and in_ready=1 immediately.
  - After release, a fresh forward R=1 block produces the correct result.

Source files
------------

// File: rtl/permute_iter_if.sv
// Handshake bundle for permute_iter: input block channel, result channel and busy flag.
interface permute_iter_if #(
    parameter int unsigned DW    = 1024,
    parameter int unsigned RND_W = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             mode;
    logic [RND_W-1:0] rounds;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic             busy;

    // Producer/consumer side driving blocks in and taking results out.
    modport master (
        output in_valid,
        output in_data,
        output mode,
        output rounds,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

    // Permutation engine side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  mode,
        input  rounds,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );

endinterface

// File: rtl/permute_iter.sv
// Iterative word permutation engine: captures one NWORDS x WORD_W block, applies a fixed
// word permutation (forward or inverse) once per clock for a programmable number of rounds,
// then presents the result until the consumer takes it.
module permute_iter #(
    parameter int unsigned               WORD_W = 64,
    parameter int unsigned               NWORDS = 16,
    parameter int unsigned               IDX_W  = 4,
    parameter logic [NWORDS*IDX_W-1:0]   PERM   = 64'hF6D294B0583C1A7E,
    parameter int unsigned               RND_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    permute_iter_if.slave  bus
);

    localparam int unsigned DW = NWORDS * WORD_W;

    // True when every output slot names a distinct, in-range source word.
    function automatic logic perm_is_bijection(input logic [NWORDS*IDX_W-1:0] p);
        logic [NWORDS-1:0] seen;
        int unsigned       idx;
        seen = '0;
        for (int j = 0; j < int'(NWORDS); j++) begin
            idx = int'(p[j*IDX_W +: IDX_W]);
            if (idx < NWORDS) begin
                seen[idx] = 1'b1;
            end
        end
        return &seen;
    endfunction

    // Inverse table: entry PERM[j] holds j, so an inverse round is also a plain gather.
    function automatic logic [NWORDS*IDX_W-1:0] inv_table(input logic [NWORDS*IDX_W-1:0] p);
        logic [NWORDS*IDX_W-1:0] t;
        int unsigned             idx;
        t = '0;
        for (int j = 0; j < int'(NWORDS); j++) begin
            idx = int'(p[j*IDX_W +: IDX_W]);
            if (idx < NWORDS) begin
                t[idx*IDX_W +: IDX_W] = IDX_W'(j);
            end
        end
        return t;
    endfunction

    localparam logic [NWORDS*IDX_W-1:0] PermInv = inv_table(PERM);

    if (!perm_is_bijection(PERM)) begin : g_bad_perm
        $error("permute_iter: PERM is not a bijection");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [DW-1:0]    r_data;
    logic [DW-1:0]    w_data_d;
    logic [RND_W-1:0] r_cnt;
    logic [RND_W-1:0] w_cnt_d;
    logic             r_mode;
    logic             w_mode_d;
    logic [DW-1:0]    w_round;

    // One round is pure wiring: each output word picks its forward or inverse source.
    for (genvar i = 0; i < int'(NWORDS); i++) begin : g_word
        localparam int unsigned FwdSrc = int'(PERM[i*IDX_W +: IDX_W]);
        localparam int unsigned InvSrc = int'(PermInv[i*IDX_W +: IDX_W]);

        assign w_round[i*WORD_W +: WORD_W] = r_mode ? r_data[InvSrc*WORD_W +: WORD_W]
                                                    : r_data[FwdSrc*WORD_W +: WORD_W];
    end

    // Next-state and datapath selection; everything holds unless the current state acts.
    always_comb begin
        w_state_d = r_state;
        w_data_d  = r_data;
        w_cnt_d   = r_cnt;
        w_mode_d  = r_mode;
        case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_data_d  = bus.in_data;
                    w_mode_d  = bus.mode;
                    w_cnt_d   = bus.rounds;
                    // Zero rounds skips RUN and returns the block untouched.
                    w_state_d = (bus.rounds == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                w_data_d = w_round;
                w_cnt_d  = r_cnt - RND_W'(1);
                if (r_cnt == RND_W'(1)) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                // Back to IDLE first, so a result and a new block never share an edge.
                if (bus.out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State and block registers; reset discards any in-flight block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_data  <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_data  <= w_data_d;
            r_cnt   <= w_cnt_d;
            r_mode  <= w_mode_d;
        end
    end

    // Handshake outputs come straight from registered state, never from inputs.
    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.busy      = (r_state != StIdle);
    assign bus.out_data  = r_data;

endmodule

// File: tb/tb_permute_iter.sv
// Bench for permute_iter: directed blocks with literal expectations plus a word-array model
// checked against the DUT outputs on every falling edge.
module tb_permute_iter;

    localparam int unsigned WORD_W = 64;
    localparam int unsigned NWORDS = 16;
    localparam int unsigned RND_W  = 4;
    localparam int unsigned DW     = NWORDS * WORD_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    permute_iter_if #(.DW(DW), .RND_W(RND_W)) bus ();

    permute_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Permutation table as written in the datasheet, entry 15 first.
    int spec_perm [16] = '{15, 6, 13, 2, 9, 4, 11, 0, 5, 8, 3, 12, 1, 10, 7, 14};
    // Hand-derived results for input word k = k.
    int exp_fwd_hi2lo [16] = '{15, 6, 13, 2, 9, 4, 11, 0, 5, 8, 3, 12, 1, 10, 7, 14};
    int exp_inv_lo2hi [16] = '{8, 3, 12, 5, 10, 7, 14, 1, 6, 11, 2, 9, 4, 13, 0, 15};

    function automatic logic [DW-1:0] model_apply(input logic [DW-1:0] d, input logic m,
                                                  input int r);
        logic [WORD_W-1:0] cur [NWORDS];
        logic [WORD_W-1:0] nxt [NWORDS];
        logic [DW-1:0]     res;
        int                src;
        for (int k = 0; k < int'(NWORDS); k++) cur[k] = d[k*WORD_W +: WORD_W];
        for (int n = 0; n < r; n++) begin
            for (int j = 0; j < int'(NWORDS); j++) begin
                src = spec_perm[NWORDS-1-j];
                if (!m) nxt[j] = cur[src];
                else    nxt[src] = cur[j];
            end
            cur = nxt;
        end
        for (int k = 0; k < int'(NWORDS); k++) res[k*WORD_W +: WORD_W] = cur[k];
        return res;
    endfunction

    function automatic logic [DW-1:0] rand_block();
        logic [DW-1:0] d;
        for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        int k;
        checks++;
        if (act !== exp) begin
            failures++;
            k = 0;
            for (int i = int'(NWORDS) - 1; i >= 0; i--) begin
                if (act[i*WORD_W +: WORD_W] !== exp[i*WORD_W +: WORD_W]) k = i;
            end
            $display("FAIL %s: word %0d got %h expected %h", name, k,
                     act[k*WORD_W +: WORD_W], exp[k*WORD_W +: WORD_W]);
        end
    endtask

    // Transaction-level model: a pending result becomes visible R edges after its accept.
    logic          m_pend = 1'b0;
    logic          m_zero = 1'b1;
    logic [DW-1:0] m_res  = '0;
    int            m_done = 0;
    int            cyc    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 1'b0;
            m_zero = 1'b1;
            m_res  = '0;
        end else begin
            cyc++;
            if (!m_pend) begin
                if (bus.in_valid) begin
                    m_pend = 1'b1;
                    m_zero = 1'b0;
                    m_res  = model_apply(bus.in_data, bus.mode, int'(bus.rounds));
                    m_done = cyc + int'(bus.rounds);
                end
            end else if ((cyc - 1 >= m_done) && bus.out_ready) begin
                m_pend = 1'b0;
            end
        end
    end

    // Every falling edge: handshake flags and data against the model.
    always @(negedge clk) begin
        logic exp_valid;
        exp_valid = m_pend && (cyc >= m_done);
        check("cmp_in_ready", DW'(bus.in_ready), DW'(!m_pend));
        check("cmp_out_valid", DW'(bus.out_valid), DW'(exp_valid));
        check("cmp_busy", DW'(bus.busy), DW'(m_pend));
        if (exp_valid) check("cmp_out_data", bus.out_data, m_res);
        if (m_zero) check("cmp_out_data_zero", bus.out_data, '0);
    end

    task automatic send(input logic [DW-1:0] d, input logic m, input logic [RND_W-1:0] r);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.mode     = m;
        bus.rounds   = r;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int lat, output logic [DW-1:0] d);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (bus.out_valid !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: out_valid never rose within %0d cycles", name, lat);
        end
        d = bus.out_data;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] kdata, exp_fwd, exp_inv, rnd, got, a_blk, a_exp;
        int            lat, n;

        for (int k = 0; k < int'(NWORDS); k++) begin
            kdata[k*WORD_W +: WORD_W]   = WORD_W'(k);
            exp_fwd[k*WORD_W +: WORD_W] = WORD_W'(exp_fwd_hi2lo[NWORDS-1-k]);
            exp_inv[k*WORD_W +: WORD_W] = WORD_W'(exp_inv_lo2hi[k]);
        end

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.mode      = 1'b0;
        bus.rounds    = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_in_ready", DW'(bus.in_ready), DW'(1));
        check("reset_out_valid", DW'(bus.out_valid), DW'(0));
        check("reset_busy", DW'(bus.busy), DW'(0));
        check("reset_out_data", bus.out_data, '0);
        rst = 1'b0;

        // Pin the model to hand-computed results.
        check("model_fwd_r1", model_apply(kdata, 1'b0, 1), exp_fwd);
        check("model_inv_r1", model_apply(kdata, 1'b1, 1), exp_inv);

        // Forward, one round.
        send(kdata, 1'b0, 4'd1);
        wait_valid("fwd_r1", lat, got);
        check("fwd_r1_latency", DW'(lat), DW'(1));
        check("fwd_r1_data", got, exp_fwd);

        // Inverse of the previous result restores the original.
        send(got, 1'b1, 4'd1);
        wait_valid("inv_r1", lat, got);
        check("inv_r1_latency", DW'(lat), DW'(1));
        check("inv_r1_data", got, kdata);

        // Four forward rounds are the identity for this table.
        rnd = rand_block();
        check("model_r4_identity", model_apply(rnd, 1'b0, 4), rnd);
        send(rnd, 1'b0, 4'd4);
        wait_valid("fwd_r4", lat, got);
        check("fwd_r4_latency", DW'(lat), DW'(4));
        check("fwd_r4_data", got, rnd);

        // Two rounds: 9 and 11 back home, 8 and 14 exchanged.
        send(rnd, 1'b0, 4'd2);
        wait_valid("fwd_r2", lat, got);
        check("fwd_r2_latency", DW'(lat), DW'(2));
        check("fwd_r2_w11", DW'(got[11*WORD_W +: WORD_W]), DW'(rnd[11*WORD_W +: WORD_W]));
        check("fwd_r2_w9", DW'(got[9*WORD_W +: WORD_W]), DW'(rnd[9*WORD_W +: WORD_W]));
        check("fwd_r2_w14", DW'(got[14*WORD_W +: WORD_W]), DW'(rnd[8*WORD_W +: WORD_W]));
        check("fwd_r2_w8", DW'(got[8*WORD_W +: WORD_W]), DW'(rnd[14*WORD_W +: WORD_W]));

        // Zero rounds: pass-through, busy for a single cycle.
        rnd = rand_block();
        send(rnd, 1'b1, 4'd0);
        wait_valid("r0", lat, got);
        check("r0_latency", DW'(lat), DW'(0));
        check("r0_data", got, rnd);
        n = 0;
        while (bus.busy === 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("r0_busy_cycles", DW'(n), DW'(1));

        // Backpressure with a competing block waiting at the input.
        a_blk = rand_block();
        a_exp = model_apply(a_blk, 1'b0, 3);
        bus.out_ready = 1'b0;
        send(a_blk, 1'b0, 4'd3);
        bus.in_valid = 1'b1;
        bus.in_data  = kdata;
        bus.mode     = 1'b1;
        bus.rounds   = 4'd1;
        wait_valid("bp_a", lat, got);
        check("bp_a_latency", DW'(lat), DW'(3));
        check("bp_a_data", got, a_exp);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_hold_data", bus.out_data, a_exp);
            check("bp_hold_in_ready", DW'(bus.in_ready), DW'(0));
            check("bp_hold_out_valid", DW'(bus.out_valid), DW'(1));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_consumed_in_ready", DW'(bus.in_ready), DW'(1));
        check("bp_consumed_out_valid", DW'(bus.out_valid), DW'(0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_b_accepted_busy", DW'(bus.busy), DW'(1));
        wait_valid("bp_b", lat, got);
        check("bp_b_latency", DW'(lat), DW'(1));
        check("bp_b_data", got, exp_inv);

        // Reset in the middle of a long run.
        send(rand_block(), 1'b0, 4'd15);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", DW'(bus.out_valid), DW'(0));
        check("rst_mid_out_data", bus.out_data, '0);
        check("rst_mid_in_ready", DW'(bus.in_ready), DW'(1));
        check("rst_mid_busy", DW'(bus.busy), DW'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(kdata, 1'b0, 4'd1);
        wait_valid("post_rst", lat, got);
        check("post_rst_latency", DW'(lat), DW'(1));
        check("post_rst_data", got, exp_fwd);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
